pwm_cmp: RTL and testbench
==========================

Name: pwm_cmp

Overview:
- Compare/PWM stage directly downstream of the free-running up-counter.
- Samples the counter's count value and top every clock and drives a registered PWM waveform.
- Duty changes go through a shadow register that is applied only at period boundaries, so the output never glitches.
- Optional burst mode emits N periods and then stops with a done pulse; software or an upstream sequencer controls it.

Parameters:
- width, 32, width of cnt/top/duty; must match the feeding counter.
- polarity, 1, active level of pwm_out (1 = active-high, 0 = active-low).
- burst_w, 8, width of the burst period count.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- cnt  in  width  count value from the upstream up-counter (0..top).
- top  in  width  period top value, the same one driving the counter.
- en  in  1  enable; a 0->1 edge starts a run.
- duty_wr  in  1  one-cycle strobe that captures duty into the shadow register.
- duty  in  width  requested active length in counts.
- burst  in  burst_w  number of periods per run; 0 = continuous.
- pwm_out  out  1  registered PWM output.
- duty_pend  out  1  shadow written but not yet applied.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (rstn=0, asynchronous), values held while low:
  - pwm_out=~polarity; done=0; duty_pend=0.
  - duty_act=0; duty_shd=0; rem=0; en_q=0; state=IDLE.
- Boundary: bnd = (state==RUN) && (cnt==top). The cycle with cnt==top is the last count of a period.
- Compare:
  - In RUN: pwm_out <= (cnt < duty_act) ? polarity : ~polarity.
  - Outside RUN: pwm_out <= ~polarity.
  - Latency is one clock from cnt to pwm_out.
  - Comparison is unsigned and full width; no truncation.
  - duty_act=0 gives a constantly inactive output.
  - duty_act>top gives a constantly active output; no wrap.
- Shadow:
  - duty_wr: duty_shd<=duty, duty_pend<=1.
  - bnd with duty_pend=1 and no duty_wr in the same cycle: duty_act<=duty_shd, duty_pend<=0.
  - duty_wr and bnd in the same cycle: the new value goes into the shadow, duty_pend stays 1, and the value is applied at the next boundary. The older shadow is discarded.
  - The compare in the boundary cycle uses the old duty_act. The new duty takes effect from cnt==0 of the next period.
- en edge detect: en_q <= en; start = en & ~en_q.
- FSM:
  - IDLE:
    - start -> RUN, rem<=burst (latched; later changes to burst are ignored until the next start).
    - If duty_pend, duty_act<=duty_shd and duty_pend<=0 on entry, so the first period uses the latest duty.
  - RUN:
    - en=0 -> IDLE immediately; the output goes idle on the next clock; no done.
    - bnd && rem!=0 && rem==1 -> DONE, done<=1 for one cycle.
    - bnd && rem>1 -> rem<=rem-1.
    - rem==0 -> continuous operation; never goes to DONE.
  - DONE: output idle; stays until en=0 -> IDLE. A new run requires an en 0->1 edge.
- Start mid-period: the output follows cnt immediately. The first "period" counted toward the burst ends at the first cnt==top, so it may be partial. This is documented and accepted; the upstream must start the counter in sync if exact periods are required.
- cnt>top (top lowered mid-period): no boundary until the counter reloads, and the compare still applies. Boundary detection is the counter's responsibility.
- done is never asserted outside the DONE transition. duty_pend is unaffected by en.

Decomposition:
- Shared package:
  - FSM state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - POL_HIGH/POL_LOW constants next to CNT_UP/CNT_DOWN.
- Sub-module pwm_shadow: the duty_shd/duty_act/duty_pend register pair with its apply rule; reusable for top shadowing later.
- FSM, burst counter and compare stay in pwm_cmp.

Test Plan (width=8, polarity=1, counter top=4, freerun, period 5 clks):
- Continuous duty: duty_wr duty=2 while idle, en=1, burst=0 -> pwm_out high for 2 clks, low for 3, repeating, delayed one clk after cnt; done never asserted.
- Shadow update: mid-period at cnt=1, duty_wr duty=4 -> duty_pend=1 until the cycle after cnt==4; the next period is high 4/low 1; no short or extra pulse in the current period.
- Collision: duty_wr duty=3 in the cnt==4 cycle -> duty_pend stays 1; the next period uses the old duty; duty=3 applies one period later.
- Extremes: duty=0 -> pwm_out constantly 0. duty=5 and duty=255 -> pwm_out constantly 1. Both apply only at boundaries.
- Burst: burst=3, en rising at cnt==0 -> exactly 3 periods of PWM, a single done pulse in the clk after the third cnt==4, then pwm_out=0. en held high -> stays in DONE; toggling en 0->1 restarts 3 periods.
- Abort/reset: en=0 mid-burst -> pwm_out=0 next clk, no done. rstn=0 mid-period -> pwm_out=0, duty_pend=0, done=0 asynchronously, before the next edge.

Source files
------------

// File: rtl/pwm_cmp_pkg.sv
// Purpose: shared constants for the PWM compare stage and its upstream counter.
// Contents: FSM state encoding, output polarity constants, counter direction constants.
package pwm_cmp_pkg;

   // FSM state encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Active level of pwm_out
   localparam logic POL_HIGH = 1'b1;
   localparam logic POL_LOW  = 1'b0;

   // Count direction of the feeding counter
   localparam logic CNT_UP   = 1'b0;
   localparam logic CNT_DOWN = 1'b1;

endpackage

// File: rtl/pwm_shadow.sv
// Purpose: shadow/active register pair; a write lands in the shadow and is
//          copied to the active value on the next apply pulse.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   wr, wdata   one-cycle write strobe and data into the shadow
//   apply       apply point (period boundary or run start)
//   act         active value
//   pend        shadow written but not yet applied
module pwm_shadow #(
   parameter int unsigned width = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr,
   input  logic [width-1:0] wdata,
   input  logic             apply,
   output logic [width-1:0] act,
   output logic             pend
);

   logic [width-1:0] shd_q, shd_d;
   logic [width-1:0] act_q, act_d;
   logic             pend_q, pend_d;

   // A write colliding with an apply wins: the new value stays pending for
   // the following apply and the older shadow is discarded.
   always_comb begin
      shd_d  = shd_q;
      act_d  = act_q;
      pend_d = pend_q;
      if (wr) begin
         shd_d  = wdata;
         pend_d = 1'b1;
      end else if (apply && pend_q) begin
         act_d  = shd_q;
         pend_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shd_q  <= '0;
         act_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         shd_q  <= shd_d;
         act_q  <= act_d;
         pend_q <= pend_d;
      end
   end

   assign act  = act_q;
   assign pend = pend_q;

endmodule

// File: rtl/pwm_cmp.sv
// Purpose: PWM compare stage fed by a free-running up-counter, with shadowed
//          duty updates at period boundaries and an optional N-period burst.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   cnt, top    counter value and period top from the upstream counter
//   en          enable; a 0->1 edge starts a run
//   duty_wr     strobe capturing duty into the shadow register
//   duty        requested active length in counts
//   burst       periods per run, 0 = continuous
//   pwm_out     registered PWM output
//   duty_pend   shadow written but not yet applied
//   done        one-cycle pulse when a burst completes
module pwm_cmp
   import pwm_cmp_pkg::*;
#(
   parameter int unsigned width    = 32,
   parameter logic        polarity = POL_HIGH,
   parameter int unsigned burst_w  = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [width-1:0]   cnt,
   input  logic [width-1:0]   top,
   input  logic               en,
   input  logic               duty_wr,
   input  logic [width-1:0]   duty,
   input  logic [burst_w-1:0] burst,
   output logic               pwm_out,
   output logic               duty_pend,
   output logic               done
);

   logic [1:0]         state_q, state_d;
   logic [burst_w-1:0] rem_q, rem_d;
   logic               en_q, en_d;
   logic               pwm_q, pwm_d;
   logic               done_q, done_d;

   logic [width-1:0]   duty_act;
   logic               start_c;
   logic               bnd_c;
   logic               apply_c;

   assign start_c = en & ~en_q;
   assign bnd_c   = (state_q == RUN) && (cnt == top);
   // Pending duty is applied at boundaries and on run start
   assign apply_c = bnd_c | ((state_q == IDLE) & start_c);

   pwm_shadow #(
      .width (width)
   ) u_shadow (
      .clk   (clk),
      .rstn  (rstn),
      .wr    (duty_wr),
      .wdata (duty),
      .apply (apply_c),
      .act   (duty_act),
      .pend  (duty_pend)
   );

   // Next-state, burst counter and compare
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      en_d    = en;
      done_d  = 1'b0;
      pwm_d   = ~polarity;
      case (state_q)
         IDLE: begin
            if (start_c) begin
               state_d = RUN;
               rem_d   = burst;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
            end else begin
               pwm_d = (cnt < duty_act) ? polarity : ~polarity;
               // rem==0 means continuous: never decremented, never done
               if (bnd_c) begin
                  if (rem_q == burst_w'(1)) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else if (rem_q > burst_w'(1)) begin
                     rem_d = rem_q - burst_w'(1);
                  end
               end
            end
         end
         DONE: begin
            if (!en) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         rem_q   <= '0;
         en_q    <= 1'b0;
         pwm_q   <= ~polarity;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         en_q    <= en_d;
         pwm_q   <= pwm_d;
         done_q  <= done_d;
      end
   end

   assign pwm_out = pwm_q;
   assign done    = done_q;

endmodule

// File: tb/tb_pwm_cmp.sv
// Purpose: self-checking bench for pwm_cmp (width=8, active-high, top=4).
//          A behavioural model predicts pwm_out/duty_pend/done every cycle;
//          hand-computed waveform vectors pin the model.
module tb_pwm_cmp;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic [7:0] cnt = 8'd0;
   logic [7:0] top = 8'd4;
   logic       en = 1'b0;
   logic       duty_wr = 1'b0;
   logic [7:0] duty = 8'd0;
   logic [7:0] burst = 8'd0;
   logic       pwm_out;
   logic       duty_pend;
   logic       done;

   int n_total = 0;
   int n_bad   = 0;

   // Model state: run/finished flags, periods left, duty registers
   logic       m_running = 1'b0;
   logic       m_finished = 1'b0;
   logic [7:0] m_left = 8'd0;
   logic [7:0] m_act = 8'd0;
   logic [7:0] m_shd = 8'd0;
   logic       m_pend = 1'b0;
   logic       m_en_prev = 1'b0;
   logic       e_pwm = 1'b0;
   logic       e_done = 1'b0;

   pwm_cmp #(
      .width    (8),
      .polarity (1'b1),
      .burst_w  (8)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cnt       (cnt),
      .top       (top),
      .en        (en),
      .duty_wr   (duty_wr),
      .duty      (duty),
      .burst     (burst),
      .pwm_out   (pwm_out),
      .duty_pend (duty_pend),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_running  = 1'b0;
      m_finished = 1'b0;
      m_left     = 8'd0;
      m_act      = 8'd0;
      m_shd      = 8'd0;
      m_pend     = 1'b0;
      m_en_prev  = 1'b0;
      e_pwm      = 1'b0;
      e_done     = 1'b0;
   endtask

   // One clock of the behavioural model, using the inputs seen at the edge
   task automatic model_step();
      logic rise;
      logic period_end;
      rise       = en && !m_en_prev;
      period_end = m_running && (cnt == top);
      e_pwm      = m_running && en && (cnt < m_act);
      e_done     = 1'b0;
      if (duty_wr) begin
         m_shd  = duty;
         m_pend = 1'b1;
      end else if (m_pend && (period_end || (!m_running && !m_finished && rise))) begin
         m_act  = m_shd;
         m_pend = 1'b0;
      end
      if (m_running) begin
         if (!en) begin
            m_running = 1'b0;
         end else if (period_end && m_left == 8'd1) begin
            m_running  = 1'b0;
            m_finished = 1'b1;
            e_done     = 1'b1;
         end else if (period_end && m_left > 8'd1) begin
            m_left = m_left - 8'd1;
         end
      end else if (m_finished) begin
         if (!en) m_finished = 1'b0;
      end else if (rise) begin
         m_running = 1'b1;
         m_left    = burst;
      end
      m_en_prev = en;
   endtask

   // Clock edge, model update, compare at the falling edge, advance counter
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("pwm_out", 32'(pwm_out), 32'(e_pwm));
      check("duty_pend", 32'(duty_pend), 32'(m_pend));
      check("done", 32'(done), 32'(e_done));
      cnt = (cnt == top) ? 8'd0 : cnt + 8'd1;
   endtask

   // Step until the next sampled count equals v
   task automatic wait_cnt(input logic [7:0] v);
      for (int i = 0; i < 10 && cnt != v; i++) step();
   endtask

   logic [31:0] pv;
   logic [31:0] dv;
   int          nd;
   logic [7:0]  dt [3] = '{8'd0, 8'd5, 8'd255};
   logic [31:0] et [3] = '{32'd0, 32'b11111, 32'b11111};

   initial begin
      // asynchronous reset
      #2 rstn = 1'b0;
      #1;
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_pend", 32'(duty_pend), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // continuous duty=2, written while idle
      duty = 8'd2; duty_wr = 1'b1; step(); duty_wr = 1'b0;
      check("idle_pend", 32'(duty_pend), 32'd1);
      burst = 8'd0;
      wait_cnt(8'd4);
      en = 1'b1; step();
      pv = '0;
      for (int i = 0; i < 10; i++) begin step(); pv = {pv[30:0], pwm_out}; end
      check("cont_pwm", pv, 32'b1100011000);

      // shadow update mid-period
      wait_cnt(8'd1);
      duty = 8'd4; duty_wr = 1'b1;
      pv = '0; dv = '0;
      for (int i = 0; i < 8; i++) begin
         step(); duty_wr = 1'b0;
         pv = {pv[30:0], pwm_out}; dv = {dv[30:0], duty_pend};
      end
      check("shadow_pwm", pv, 32'b10001111);
      check("shadow_pend", dv, 32'b11100000);

      // write colliding with a boundary
      wait_cnt(8'd4);
      duty = 8'd3; duty_wr = 1'b1;
      pv = '0; dv = '0;
      for (int i = 0; i < 11; i++) begin
         step(); duty_wr = 1'b0;
         pv = {pv[30:0], pwm_out}; dv = {dv[30:0], duty_pend};
      end
      check("collide_pwm", pv, 32'b01111011100);
      check("collide_pend", dv, 32'b11111000000);

      // extremes: 0 -> always low; 5 and 255 -> always high
      for (int k = 0; k < 3; k++) begin
         wait_cnt(8'd2);
         duty = dt[k]; duty_wr = 1'b1; step(); duty_wr = 1'b0;
         wait_cnt(8'd0);
         pv = '0;
         for (int i = 0; i < 5; i++) begin step(); pv = {pv[30:0], pwm_out}; end
         check("extreme_pwm", pv, et[k]);
      end

      // burst of 3 periods
      en = 1'b0; step();
      duty = 8'd2; duty_wr = 1'b1; step(); duty_wr = 1'b0;
      burst = 8'd3;
      wait_cnt(8'd4);
      en = 1'b1; step();
      pv = '0; dv = '0;
      for (int i = 0; i < 18; i++) begin
         step(); pv = {pv[30:0], pwm_out}; dv = {dv[30:0], done};
      end
      check("burst_pwm", pv, 32'b110001100011000000);
      check("burst_done", dv, 32'b000000000000001000);
      for (int i = 0; i < 5; i++) step();
      check("done_hold_pwm", 32'(pwm_out), 32'd0);

      // re-arm with an en 0->1 edge
      en = 1'b0; step();
      en = 1'b1;
      nd = 0;
      for (int i = 0; i < 25; i++) begin step(); nd += int'(done); end
      check("rearm_done_cnt", 32'(nd), 32'd1);

      // abort mid-burst
      en = 1'b0; step();
      wait_cnt(8'd4);
      en = 1'b1; step();
      for (int i = 0; i < 7; i++) step();
      check("abort_pre_pwm", 32'(pwm_out), 32'd1);
      en = 1'b0; step();
      check("abort_pwm", 32'(pwm_out), 32'd0);
      nd = 0;
      for (int i = 0; i < 10; i++) begin step(); nd += int'(done); end
      check("abort_done_cnt", 32'(nd), 32'd0);

      // asynchronous reset mid-period
      burst = 8'd0;
      wait_cnt(8'd4);
      en = 1'b1; step();
      step();
      duty = 8'd3; duty_wr = 1'b1; step(); duty_wr = 1'b0;
      check("pre_rst_pwm", 32'(pwm_out), 32'd1);
      check("pre_rst_pend", 32'(duty_pend), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("async_rst_pwm", 32'(pwm_out), 32'd0);
      check("async_rst_pend", 32'(duty_pend), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      model_reset();
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_hold_pwm", 32'(pwm_out), 32'd0);
      rstn = 1'b1;
      cnt = 8'd0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
